// File: rtl/hamming74_encoder_tx.sv
`default_nettype none
// hamming74_encoder_tx: splits each accepted byte into two nibbles and emits each
// nibble as a Hamming(7,4) codeword over a valid/ready handshake.
module hamming74_encoder_tx #(
  parameter int HI_FIRST   = 0,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [6:0]       io_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [6:0]       io_out_q, io_out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic [3:0]       gap_q, gap_d;

  // Bit order is Hamming positions 7..1: {d4,d3,d2,p4,d1,p2,p1}.
  function automatic logic [6:0] encode(input logic [3:0] n);
    return {n[3], n[2], n[1], n[1] ^ n[2] ^ n[3],
            n[0], n[0] ^ n[2] ^ n[3], n[0] ^ n[1] ^ n[3]};
  endfunction

  function automatic logic [3:0] first_nibble(input logic [7:0] b);
    return (HI_FIRST != 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [3:0] second_nibble(input logic [7:0] b);
    return (HI_FIRST != 0) ? b[3:0] : b[7:4];
  endfunction

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    io_out_d     = io_out_q;
    out_valid_d  = out_valid_q;
    in_ready_d   = in_ready_q;
    byte_count_d = byte_count_q;
    gap_d        = gap_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d      = in_data;
          io_out_d    = encode(first_nibble(in_data));
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          state_d     = SEND0;
        end
      end
      SEND0: begin
        if (out_ready) begin
          io_out_d = encode(second_nibble(data_q));
          state_d  = SEND1;
        end
      end
      SEND1: begin
        if (out_ready) begin
          byte_count_d = byte_count_q + 1'b1;
          out_valid_d  = 1'b0;
          gap_d        = 4'd0;
          if (GAP_CYCLES == 0) begin
            in_ready_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d      = 4'd0;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= 8'd0;
      io_out_q     <= 7'd0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      byte_count_q <= '0;
      gap_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      io_out_q     <= io_out_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      byte_count_q <= byte_count_d;
      gap_q        <= gap_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign io_out     = io_out_q;
  assign out_valid  = out_valid_q;
  assign byte_count = byte_count_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hamming74_encoder_tx.sv
`default_nettype none
// Bench for hamming74_encoder_tx: table vectors, a positional Hamming reference model,
// randomized traffic with a scoreboard, and hand-written multi-cycle corner cases.
module tb_hamming74_encoder_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // DUT A: low nibble first, 2 gap cycles, 16-bit counter
  logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0]  a_in_data;
  logic [6:0]  a_io_out;
  logic [15:0] a_byte_count;
  // DUT B: high nibble first, no gap, 4-bit counter
  logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_in_data;
  logic [6:0]  b_io_out;
  logic [3:0]  b_byte_count;

  hamming74_encoder_tx #(.HI_FIRST(0), .GAP_CYCLES(2), .CNT_W(16)) dut_a (
    .clock(clock), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .io_out(a_io_out), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .byte_count(a_byte_count), .busy(a_busy));

  hamming74_encoder_tx #(.HI_FIRST(1), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
    .clock(clock), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .io_out(b_io_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .byte_count(b_byte_count), .busy(b_busy));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference encoder: data bits fill non-power-of-two positions, parity bit at 2^k
  // makes the XOR over all positions with bit k set equal to zero.
  function automatic logic [6:0] model_encode(input logic [3:0] n);
    logic [7:1] cw;
    int di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos <= 7; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = n[di];
        di++;
      end
    for (int k = 0; k < 3; k++)
      for (int pos = 1; pos <= 7; pos++)
        if ((pos & (1 << k)) != 0 && pos != (1 << k)) cw[1 << k] ^= cw[pos];
    return cw;
  endfunction

  function automatic logic [2:0] model_syndrome(input logic [6:0] cw);
    logic [2:0] s;
    s = 3'd0;
    for (int pos = 1; pos <= 7; pos++)
      if (cw[pos-1]) s ^= 3'(pos);
    return s;
  endfunction

  function automatic logic [3:0] model_data(input logic [6:0] cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

  // Scoreboard for DUT A, active once the initial reset is done
  logic       mon_en = 1'b0;
  logic [6:0] expq[$];
  int         model_count = 0;
  int         cw_in_byte = 0;
  logic       prev_stall = 1'b0;
  logic [6:0] prev_code = 7'd0;
  logic       exp_valid_next = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (a_reset) begin
        expq.delete();
        model_count = 0;
        cw_in_byte = 0;
        prev_stall = 1'b0;
        exp_valid_next = 1'b0;
      end else begin
        check("byte_count", 32'(a_byte_count), 32'(16'(model_count)));
        if (exp_valid_next) check("first_cw_latency", 32'(a_out_valid), 32'd1);
        if (prev_stall) begin
          check("stall_valid", 32'(a_out_valid), 32'd1);
          check("stall_data", 32'(a_io_out), 32'(prev_code));
        end
        if (expq.size() != 0) check("in_ready_while_busy", 32'(a_in_ready), 32'd0);
        exp_valid_next = 1'b0;
        if (a_in_valid && a_in_ready) begin
          check("accept_when_empty", 32'(expq.size()), 32'd0);
          expq.push_back(model_encode(a_in_data[3:0]));
          expq.push_back(model_encode(a_in_data[7:4]));
          exp_valid_next = 1'b1;
        end
        if (a_out_valid && a_out_ready) begin
          check("codeword_expected", 32'(expq.size() != 0), 32'd1);
          if (expq.size() != 0) begin
            check("codeword", 32'(a_io_out), 32'(expq.pop_front()));
            cw_in_byte++;
            if (cw_in_byte == 2) begin
              cw_in_byte = 0;
              model_count++;
            end
          end
        end
        prev_stall = a_out_valid && !a_out_ready;
        prev_code = a_io_out;
      end
    end
  end

  task automatic a_send(input logic [7:0] d, output logic [6:0] c0, output logic [6:0] c1);
    int got;
    logic drop;
    got = 0;
    drop = 1'b0;
    c0 = 7'd0;
    c1 = 7'd0;
    a_in_valid = 1'b1;
    a_in_data = d;
    a_out_ready = 1'b1;
    for (int i = 0; i < 30 && got < 2; i++) begin
      @(negedge clock);
      if (a_out_valid && a_out_ready) begin
        if (got == 0) c0 = a_io_out;
        else c1 = a_io_out;
        got++;
      end
      if (a_in_valid && a_in_ready) drop = 1'b1;
      @(posedge clock); #1;
      if (drop) a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    check("send_done", 32'(got), 32'd2);
  endtask

  task automatic a_wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clock);
      if (!a_busy) idle = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
    check("wait_idle", 32'(idle), 32'd1);
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [6:0] c0;
    logic [6:0] c1;
  } vec_t;

  vec_t       vecs[4];
  logic [6:0] c0, c1;
  logic [6:0] bq[$];
  logic [6:0] e7;
  logic [6:0] first_cw[2];
  int         bacc[17];
  int         aacc[3];
  int         nacc, ncw, gapc;
  logic       acc;

  initial begin
    vecs[0] = '{d: 8'hAB, c0: 7'h55, c1: 7'h52};
    vecs[1] = '{d: 8'h00, c0: 7'h00, c1: 7'h00};
    vecs[2] = '{d: 8'hFF, c0: 7'h7F, c1: 7'h7F};
    vecs[3] = '{d: 8'h5A, c0: 7'h52, c1: 7'h2D};

    a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = 8'd0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = 8'd0; b_out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clock);
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_io_out", 32'(a_io_out), 32'd0);
    check("rst_a_byte_count", 32'(a_byte_count), 32'd0);
    check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    check("rst_b_byte_count", 32'(b_byte_count), 32'd0);
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Known vectors, low nibble first
    for (int i = 0; i < 4; i++) begin
      a_send(vecs[i].d, c0, c1);
      check($sformatf("vec%0d_cw0", i), 32'(c0), 32'(vecs[i].c0));
      check($sformatf("vec%0d_cw1", i), 32'(c1), 32'(vecs[i].c1));
    end

    // Every nibble decodes back to itself with a zero syndrome
    for (int n = 0; n < 16; n++) begin
      a_send({4'(15 - n), 4'(n)}, c0, c1);
      check($sformatf("dec%0d_syn0", n), 32'(model_syndrome(c0)), 32'd0);
      check($sformatf("dec%0d_data0", n), 32'(model_data(c0)), 32'(n));
      check($sformatf("dec%0d_syn1", n), 32'(model_syndrome(c1)), 32'd0);
      check($sformatf("dec%0d_data1", n), 32'(model_data(c1)), 32'(15 - n));
    end

    // Randomized traffic against the scoreboard; in_data wiggles every cycle
    for (int i = 0; i < 400; i++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      a_in_data = 8'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    a_wait_idle();

    // Downstream stall for 5 cycles in SEND0
    a_in_valid = 1'b1; a_in_data = 8'h3C; a_out_ready = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clock);
      if (a_in_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    check("stall_accept", 32'(acc), 32'd1);
    a_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_hold_valid", 32'(a_out_valid), 32'd1);
      check("stall_hold_code", 32'(a_io_out), 32'(model_encode(4'hC)));
      check("stall_in_ready", 32'(a_in_ready), 32'd0);
      check("stall_busy", 32'(a_busy), 32'd1);
      @(posedge clock); #1;
    end
    a_out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("stall_second_code", 32'(a_io_out), 32'(model_encode(4'h3)));
    @(posedge clock); #1;
    a_wait_idle();

    // in_valid held high: accept spacing and GAP length
    a_in_valid = 1'b1; a_out_ready = 1'b1;
    nacc = 0; gapc = 0;
    for (int cyc = 0; cyc < 60 && nacc < 3; cyc++) begin
      @(negedge clock);
      if (nacc == 1 && !a_out_valid && a_busy) gapc++;
      if (a_in_valid && a_in_ready) begin
        aacc[nacc] = cyc;
        nacc++;
      end
      @(posedge clock); #1;
      a_in_data = 8'($urandom);
      if (nacc == 3) a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    check("hold_accepts", 32'(nacc), 32'd3);
    check("accept_spacing_1", 32'(aacc[1] - aacc[0]), 32'd5);
    check("accept_spacing_2", 32'(aacc[2] - aacc[1]), 32'd5);
    check("gap_idle_cycles", 32'(gapc), 32'd2);
    a_wait_idle();

    // Reset while in SEND1
    a_in_valid = 1'b1; a_in_data = 8'h96; a_out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clock);
      if (a_in_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    check("rst_mid_accept", 32'(acc), 32'd1);
    a_in_valid = 1'b0;
    @(posedge clock); #1;
    a_out_ready = 1'b0;
    @(negedge clock);
    check("rst_mid_send1_valid", 32'(a_out_valid), 32'd1);
    check("rst_mid_send1_code", 32'(a_io_out), 32'(model_encode(4'h9)));
    check("rst_mid_count_nonzero", 32'(a_byte_count != 16'd0), 32'd1);
    @(posedge clock); #1;
    a_reset = 1'b1;
    @(posedge clock); #1;
    a_reset = 1'b0;
    @(negedge clock);
    check("rst_mid_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_mid_busy", 32'(a_busy), 32'd0);
    check("rst_mid_byte_count", 32'(a_byte_count), 32'd0);
    check("rst_mid_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_mid_io_out", 32'(a_io_out), 32'd0);
    @(posedge clock); #1;

    // DUT B: high nibble first, no gap, 17 bytes into a 4-bit counter
    b_in_valid = 1'b1; b_in_data = 8'hAB; b_out_ready = 1'b1;
    nacc = 0; ncw = 0;
    first_cw[0] = 7'd0; first_cw[1] = 7'd0;
    for (int cyc = 0; cyc < 200 && !(nacc == 17 && bq.size() == 0); cyc++) begin
      @(negedge clock);
      if (b_out_valid && b_out_ready) begin
        check("b_codeword_expected", 32'(bq.size() != 0), 32'd1);
        if (bq.size() != 0) begin
          e7 = bq.pop_front();
          check("b_codeword", 32'(b_io_out), 32'(e7));
        end
        if (ncw < 2) first_cw[ncw] = b_io_out;
        ncw++;
      end
      if (b_in_valid && b_in_ready) begin
        bq.push_back(model_encode(b_in_data[7:4]));
        bq.push_back(model_encode(b_in_data[3:0]));
        bacc[nacc] = cyc;
        nacc++;
      end
      @(posedge clock); #1;
      b_in_data = 8'($urandom);
      if (nacc == 17) b_in_valid = 1'b0;
    end
    b_in_valid = 1'b0;
    @(negedge clock);
    check("b_accepts", 32'(nacc), 32'd17);
    check("b_codewords", 32'(ncw), 32'd34);
    check("b_hi_first_cw0", 32'(first_cw[0]), 32'h52);
    check("b_hi_first_cw1", 32'(first_cw[1]), 32'h55);
    check("b_spacing_first", 32'(bacc[1] - bacc[0]), 32'd3);
    check("b_spacing_last", 32'(bacc[16] - bacc[15]), 32'd3);
    check("b_byte_count_wrap", 32'(b_byte_count), 32'd1);
    check("b_idle_after", 32'(b_busy), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
